vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator. Combines the horizontal and vertical counters in one block.
- Produces sync pulses with configurable polarity, an active-video flag, line/frame boundary flags and a frame-start pulse.
- Sits between the pixel-clock enable divider and the pixel/colour generator.
- Supersedes the fixed single-axis modulo counters. Any mode (e.g. 640x480, 800x600) is selected by parameters only.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A horizontal pixel counter and a
// vertical line counter advance on pixel-clock enables. The block emits sync
// pulses with selectable polarity, an active-video flag, line/frame boundary
// flags and a one-enable-period frame-start pulse.
//
// Every output is a flop. Flags are decoded from the *next* counter values
// and registered together with the counters, so each flag always matches the
// hcount/vcount visible in the same cycle.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high (takes priority over ce)
//   ce           pixel-clock enable; state advances only when ce=1
//   hcount       pixel position in line, 0..H_TOTAL-1
//   vcount       line in frame, 0..V_TOTAL-1
//   hsync        horizontal sync, asserted level = HSYNC_POL
//   vsync        vertical sync, asserted level = VSYNC_POL
//   video_on     1 inside the visible window
//   line_end     1 while hcount == H_TOTAL-1
//   frame_end    1 while at the last pixel of the last line
//   frame_start  1 for one ce period after wrapping into (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_end,
    output logic          frame_end,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject timing sets that would produce empty regions or overflow the
    // counter widths.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameters");
    end

    // Region boundaries expressed in counter width. All of them are below
    // H_TOTAL / V_TOTAL, so they fit even when a total equals 2^width.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    function automatic logic hsync_of(input logic [HW-1:0] h);
        return (h >= H_SYNC_BEG && h <= H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
    endfunction

    function automatic logic vsync_of(input logic [VW-1:0] v);
        return (v >= V_SYNC_BEG && v <= V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
    endfunction

    function automatic logic video_of(input logic [HW-1:0] h,
                                      input logic [VW-1:0] v);
        return (h < H_VIS) && (v < V_VIS);
    endfunction

    logic          h_wrap;
    logic          v_wrap;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;

    // Next-position stage: where the raster will be after this enable.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_nxt  = h_wrap ? '0 : hcount + HW'(1);
        v_nxt  = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount + VW'(1);
        end
    end

    // Register stage: counters and flags decoded from the next position.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            video_on    <= 1'b1;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            video_on    <= video_of(h_nxt, v_nxt);
            hsync       <= hsync_of(h_nxt);
            vsync       <= vsync_of(v_nxt);
            line_end    <= (h_nxt == H_LAST);
            frame_end   <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
            // Only the natural wrap out of the last pixel raises this.
            frame_start <= h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clk/rst/ce:
//   u_a : default horizontal timing (800 pixels/line, active-low syncs) with
//         a short 8-line frame so whole frames fit in a short run.
//   u_b : tiny mode 8x6 with active-high syncs and counters exactly as wide
//         as the totals require.
// A reference raster position is kept per instance; expected flag values come
// from the hand-written region limits of each mode.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    logic [9:0] a_hc, a_vc;
    logic       a_hs, a_vs, a_von, a_le, a_fe, a_fs;
    logic [2:0] b_hc, b_vc;
    logic       b_hs, b_vs, b_von, b_le, b_fe, b_fs;

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_a (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(a_hc), .vcount(a_vc), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .line_end(a_le), .frame_end(a_fe),
        .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(3), .VW(3)
    ) u_b (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount(b_hc), .vcount(b_vc), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .line_end(b_le), .frame_end(b_fe),
        .frame_start(b_fs)
    );

    int checks   = 0;
    int failures = 0;

    // Reference positions and frame-start state
    int ah, av, afs;
    int bh, bv, bfs;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        // u_a: 800-pixel line, 8-line frame, syncs active-low
        chk("a_hcount",      a_hc, ah);
        chk("a_vcount",      a_vc, av);
        chk("a_video_on",    a_von, (ah < 640 && av < 4) ? 1 : 0);
        chk("a_hsync",       a_hs, (ah >= 656 && ah <= 751) ? 0 : 1);
        chk("a_vsync",       a_vs, (av >= 5 && av <= 6) ? 0 : 1);
        chk("a_line_end",    a_le, (ah == 799) ? 1 : 0);
        chk("a_frame_end",   a_fe, (ah == 799 && av == 7) ? 1 : 0);
        chk("a_frame_start", a_fs, afs);
        // u_b: 8-pixel line, 6-line frame, syncs active-high
        chk("b_hcount",      b_hc, bh);
        chk("b_vcount",      b_vc, bv);
        chk("b_video_on",    b_von, (bh < 4 && bv < 3) ? 1 : 0);
        chk("b_hsync",       b_hs, (bh >= 5 && bh <= 6) ? 1 : 0);
        chk("b_vsync",       b_vs, (bv == 4) ? 1 : 0);
        chk("b_line_end",    b_le, (bh == 7) ? 1 : 0);
        chk("b_frame_end",   b_fe, (bh == 7 && bv == 5) ? 1 : 0);
        chk("b_frame_start", b_fs, bfs);
    endtask

    // One clock: advance the reference with the inputs the DUT sampled,
    // then compare a little after the edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            ah = 0; av = 0; afs = 0;
            bh = 0; bv = 0; bfs = 0;
        end else if (ce) begin
            afs = (ah == 799 && av == 7) ? 1 : 0;
            if (ah == 799) begin
                ah = 0;
                av = (av == 7) ? 0 : av + 1;
            end else begin
                ah = ah + 1;
            end
            bfs = (bh == 7 && bv == 5) ? 1 : 0;
            if (bh == 7) begin
                bh = 0;
                bv = (bv == 5) ? 0 : bv + 1;
            end else begin
                bh = bh + 1;
            end
        end
        #1;
        check_all();
    endtask

    int a_first_fs, b_first_fs, a_fs_cnt, b_fs_cnt, b_fs_clk;

    initial begin
        // Reset with ce high: counters must stay at the (0,0) decode
        rst = 1'b1;
        ce  = 1'b1;
        repeat (3) cyc();

        // Two full u_a frames (266 u_b frames plus a partial one)
        rst = 1'b0;
        a_first_fs = -1; b_first_fs = -1; a_fs_cnt = 0; b_fs_cnt = 0;
        for (int i = 1; i <= 12800; i++) begin
            cyc();
            if (a_fs === 1'b1) begin
                a_fs_cnt++;
                if (a_first_fs < 0) a_first_fs = i;
            end
            if (b_fs === 1'b1) begin
                b_fs_cnt++;
                if (b_first_fs < 0) b_first_fs = i;
            end
        end
        chk("a_first_frame_start_ce", a_first_fs, 6400);
        chk("b_first_frame_start_ce", b_first_fs, 48);
        chk("a_frame_start_count",    a_fs_cnt, 2);
        chk("b_frame_start_count",    b_fs_cnt, 266);

        // ce on every 4th clock for 200 enables. u_b sits 32 enables into
        // its frame, so it wraps on enables 16, 64, 112 and 160, each pulse
        // lasting 4 clocks.
        b_fs_clk = 0;
        for (int i = 0; i < 800; i++) begin
            ce = ((i % 4) == 3);
            cyc();
            if (b_fs === 1'b1) b_fs_clk++;
        end
        chk("b_frame_start_clks_gated", b_fs_clk, 16);

        // u_a is now at (200,0); run to (300,5) then reset for one clock
        ce = 1'b1;
        repeat (4100) cyc();
        chk("a_pre_reset_h", a_hc, 300);
        chk("a_pre_reset_v", a_vc, 5);
        chk("a_pre_reset_vsync_active", a_vs, 0);
        rst = 1'b1;
        cyc();
        chk("a_mid_reset_h", a_hc, 0);
        chk("a_mid_reset_v", a_vc, 0);
        chk("a_mid_reset_vsync", a_vs, 1);
        rst = 1'b0;
        cyc();
        chk("a_resume_h", a_hc, 1);
        repeat (1000) cyc();

        // Reset wins even when ce is low
        rst = 1'b1;
        ce  = 1'b0;
        cyc();
        chk("a_reset_ce0_h", a_hc, 0);
        chk("b_reset_ce0_h", b_hc, 0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("a_hold_ce0_h", a_hc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
